// File: rtl/pwm_frame_demodulator.sv
// pwm_frame_demodulator: pulse-width demodulator for the downlink command channel.
// Oversamples the envelope on a prescaled tick, classifies each high pulse as bit 0 or 1
// by width, assembles MSB-first frames and decodes short/flag/scheme frames on line idle.
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   insig       asynchronous envelope input (high = carrier pulse)
//   working     synchronous frame-state clear while the tag transmits
//   frame_valid one-clock strobe on a good frame
//   frame_type  01 short, 10 flag, 11 scheme (held)
//   ord         wrapping good-frame counter
//   cur_flag    last good flag payload
//   cur_scheme  last good scheme payload
//   err         one-clock error strobe
//   err_code    01 bad width, 10 bad header/length/overflow, 11 parity (held)
module pwm_frame_demodulator #(
    parameter int PRESCALE  = 50,
    parameter int CNT_W     = 10,
    parameter int ZERO_LO   = 1,
    parameter int ZERO_HI   = 2,
    parameter int ONE_LO    = 5,
    parameter int ONE_HI    = 5,
    parameter int END_GAP   = 10,
    parameter int FLAG_W    = 8,
    parameter int SCHEME_W  = 48,
    parameter int ORD_W     = 2,
    parameter int PARITY_EN = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                insig,
    input  logic                working,
    output logic                frame_valid,
    output logic [1:0]          frame_type,
    output logic [ORD_W-1:0]    ord,
    output logic [FLAG_W-1:0]   cur_flag,
    output logic [SCHEME_W-1:0] cur_scheme,
    output logic                err,
    output logic [1:0]          err_code
);
    localparam int DEPTH = SCHEME_W + 3;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] Z_LO = CNT_W'(ZERO_LO);
    localparam logic [CNT_W-1:0] Z_HI = CNT_W'(ZERO_HI);
    localparam logic [CNT_W-1:0] O_LO = CNT_W'(ONE_LO);
    localparam logic [CNT_W-1:0] O_HI = CNT_W'(ONE_HI);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(END_GAP);
    localparam logic [LEN_W-1:0] LEN_SHORT = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_FLAG = LEN_W'(FLAG_W + 3);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DISCARD} state_t;

    state_t           state;
    logic             sync1, sync2;
    logic [PS_W-1:0]  pcnt;
    logic [DEPTH-1:0] buffer;
    logic [LEN_W-1:0] len;
    logic             parity;
    logic [CNT_W-1:0] pulse_cnt, gap_cnt;

    logic             tick, is_zero, is_one, full, gap_done, len_ok, par_bad;
    logic [CNT_W-1:0] pulse_inc, gap_inc;
    logic [1:0]       hdr;
    logic [LEN_W-1:0] need_len;

    assign tick      = pcnt == PS_W'(PRESCALE - 1);
    assign pulse_inc = (pulse_cnt == CNT_MAX) ? pulse_cnt : pulse_cnt + 1'b1;
    assign gap_inc   = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + 1'b1;
    assign gap_done  = gap_inc == GAP_END;
    assign is_zero   = pulse_cnt >= Z_LO && pulse_cnt <= Z_HI;
    assign is_one    = pulse_cnt >= O_LO && pulse_cnt <= O_HI;
    assign full      = len == LEN_FULL;
    // The first two received bits sit at the top of the filled part of the buffer.
    assign hdr       = 2'(buffer >> (len - LEN_W'(2)));
    assign need_len  = (hdr == 2'b01) ? LEN_SHORT : (hdr == 2'b10) ? LEN_FLAG : LEN_FULL;
    assign len_ok    = len >= LEN_W'(2) && hdr != 2'b00 && len == need_len;
    assign par_bad   = PARITY_EN != 0 && parity;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            pcnt        <= '0;
            buffer      <= '0;
            len         <= '0;
            parity      <= 1'b0;
            pulse_cnt   <= '0;
            gap_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_type  <= 2'b00;
            ord         <= '0;
            cur_flag    <= '0;
            cur_scheme  <= '0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            sync1       <= insig;
            sync2       <= sync1;
            pcnt        <= tick ? '0 : pcnt + 1'b1;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (working) begin
                state     <= IDLE;
                buffer    <= '0;
                len       <= '0;
                parity    <= 1'b0;
                pulse_cnt <= '0;
                gap_cnt   <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: if (sync2) begin
                        state     <= HIGH;
                        pulse_cnt <= CNT_W'(1);
                    end
                    HIGH: if (sync2) begin
                        pulse_cnt <= pulse_inc;
                    end else begin
                        pulse_cnt <= '0;
                        // The tick that ends the pulse is already the first low tick.
                        gap_cnt   <= CNT_W'(1);
                        if (!(is_zero || is_one)) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                            state    <= DISCARD;
                        end else if (full) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                            state    <= DISCARD;
                        end else begin
                            buffer <= {buffer[DEPTH-2:0], is_one};
                            parity <= parity ^ is_one;
                            len    <= len + 1'b1;
                            state  <= LOW;
                        end
                    end
                    LOW: if (sync2) begin
                        state     <= HIGH;
                        pulse_cnt <= CNT_W'(1);
                    end else begin
                        gap_cnt <= gap_inc;
                        if (gap_done) begin
                            if (!len_ok) begin
                                err      <= 1'b1;
                                err_code <= 2'b10;
                            end else if (par_bad) begin
                                err      <= 1'b1;
                                err_code <= 2'b11;
                            end else begin
                                frame_valid <= 1'b1;
                                frame_type  <= hdr;
                                ord         <= ord + 1'b1;
                                if (hdr == 2'b10) cur_flag <= buffer[FLAG_W:1];
                                if (hdr == 2'b11) cur_scheme <= buffer[SCHEME_W:1];
                            end
                            state   <= IDLE;
                            buffer  <= '0;
                            len     <= '0;
                            parity  <= 1'b0;
                            gap_cnt <= '0;
                        end
                    end
                    DISCARD: if (sync2) begin
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_inc;
                        if (gap_done) begin
                            state   <= IDLE;
                            buffer  <= '0;
                            len     <= '0;
                            parity  <= 1'b0;
                            gap_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/pwm_frame_demodulator.md
Name: pwm_frame_demodulator

Overview:
- Parametrised pulse-width demodulator for the downlink command channel.
- Oversamples the envelope input on a prescaled tick and classifies each high pulse as bit 0 or bit 1 by its width.
- Assembles MSB-first frames and, when the line goes idle, decodes three frame classes (short, flag, scheme) with an even-parity check.
- Sits between the envelope comparator input and the tag control FSM. Reports each frame with a one-cycle valid strobe, a wrapping order counter and explicit error codes.

Parameters:
- PRESCALE, 50: clock cycles per sample tick.
- CNT_W, 10: width of the pulse and gap counters; both saturate at 2^CNT_W-1.
- ZERO_LO, 1 / ZERO_HI, 2: inclusive high-width range in ticks decoded as bit 0.
- ONE_LO, 5 / ONE_HI, 5: inclusive high-width range in ticks decoded as bit 1.
- END_GAP, 10: consecutive low ticks that terminate a frame.
- FLAG_W, 8: flag payload width.
- SCHEME_W, 48: scheme payload width; sets buffer depth SCHEME_W+3.
- ORD_W, 2: width of the frame order counter.
- PARITY_EN, 1: 1 = enforce even parity; 0 = ignore parity.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- insig, in, 1: asynchronous envelope input; high = carrier pulse.
- working, in, 1: synchronous frame-state clear while the tag is transmitting.
- frame_valid, out, 1: one-clock strobe when a good frame is decoded.
- frame_type, out, 2: 01 short, 10 flag, 11 scheme; held until the next good frame.
- ord, out, ORD_W: increments on each good frame, wraps.
- cur_flag, out, FLAG_W: last good flag payload.
- cur_scheme, out, SCHEME_W: last good scheme payload.
- err, out, 1: one-clock error strobe.
- err_code, out, 2: 01 bad pulse width, 10 bad header/length/overflow, 11 parity fail; held until the next error.

Behaviour:
- Reset state (reset=0): all outputs 0, all internal registers 0, state IDLE.
- Input synchroniser: insig passes through a 2-flop synchroniser; only the synchronised value is used.
- Prescaler: free-running 0..PRESCALE-1; tick when the count equals PRESCALE-1. All state changes below occur only on tick cycles, except working and reset.
- State IDLE (len=0): sampled high -> HIGH with pulse_cnt=1.
- State HIGH: high -> pulse_cnt++ (saturating). Low -> classify pulse_cnt:
  - in [ZERO_LO,ZERO_HI]: shift in 0.
  - in [ONE_LO,ONE_HI]: shift in 1, toggle parity.
  - len++, gap_cnt=1, pulse_cnt=0, go to LOW.
  - Any other width (including saturation): err=1, err_code=01, go to DISCARD.
  - Shifting a bit when len is already SCHEME_W+3: err=1, err_code=10, go to DISCARD.
- State LOW: high -> HIGH, pulse_cnt=1. Low -> gap_cnt++; when gap_cnt reaches END_GAP, evaluate the frame (below) and return to IDLE.
- State DISCARD: ignore bits; return to IDLE after END_GAP consecutive low ticks. Buffer, len and parity clear on entry to IDLE.
- Frame evaluation. The header is the first two bits received, located at buffer[len-1:len-2].
  - 01 with len=3 -> short frame.
  - 10 with len=FLAG_W+3 -> cur_flag=buffer[FLAG_W:1].
  - 11 with len=SCHEME_W+3 -> cur_scheme=buffer[SCHEME_W:1].
  - Header 00, len<2, or header/len mismatch -> err_code=10.
  - Parity accumulator nonzero with PARITY_EN=1 -> err_code=11. Parity covers header, payload and parity bit.
  - Good frame: frame_valid=1 for one clock, frame_type updated, ord++ (mod 2^ORD_W).
  - Outputs register on the clock after the tick where gap_cnt reaches END_GAP.
  - A failed frame leaves cur_flag, cur_scheme, ord and frame_type unchanged.
- Simultaneous events:
  - err and frame_valid are never both high.
  - working=1 overrides everything except reset: on any clock it clears buffer, len, parity and counters, forces IDLE, and suppresses strobes. Held outputs and the prescaler are unaffected.
- Reset mid-frame: frame aborted, all outputs 0, no strobe.

Test Plan:
- Short frame: PRESCALE=50; pulses 1,5,5 ticks, each separated by 2 low ticks, then 10 low ticks -> frame_valid once, frame_type=01, ord=1, err stays 0.
- Flag frame: bits 1,0,10100101,1 -> cur_flag=0xA5, frame_type=10, ord increments. Repeat with final bit 0 -> err=1, err_code=11, cur_flag stays 0xA5.
- Scheme frame: header 11, payload 0x123456789ABC, correct parity -> cur_scheme=0x123456789ABC, frame_type=11. Send 52 bits -> err_code=10 at bit 52, no valid.
- Invalid width: 3-tick pulse mid-frame -> err_code=01. Pulses before the 10-tick low gap are ignored; the following short frame decodes correctly.
- working asserted after 2 bits of a flag frame, remaining bits sent -> no frame_valid; after release and gap, a fresh short frame decodes.
- Order wrap: ORD_W=2, five good short frames -> ord sequence 1,2,3,0,1. Async reset mid-frame -> all outputs 0 immediately.
